apb_mem_bridge: RTL and testbench
=================================

APB_MEM_BRIDGE -- requirements
Module: apb_mem_bridge

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the APB byte-address width (minimum 7).
REQ-002 Parameter TIMEOUT, default 8, SHALL set the maximum number of cycles spent in REQ waiting for mem_ready_i (minimum 2).
REQ-003 clk  in  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 psel_i  in  1  APB select.
REQ-006 penable_i  in  1  APB enable (access phase).
REQ-007 pwrite_i  in  1  APB direction: 1 write, 0 read.
REQ-008 paddr_i  in  ADDR_W  APB byte address.
REQ-009 pwdata_i  in  32  APB write data.
REQ-010 pready_o  out  1  APB ready, registered.
REQ-011 prdata_o  out  32  APB read data, registered.
REQ-012 pslverr_o  out  1  APB slave error, registered.
REQ-013 mem_req_o  out  1  Memory request, registered.
REQ-014 mem_rnw_o  out  1  Memory direction: 1 read, 0 write.
REQ-015 mem_addr_o  out  4  Memory word index.
REQ-016 mem_wdata_o  out  32  Memory write data.
REQ-017 mem_ready_i  in  1  Memory acknowledge; rises one cycle after mem_req_o is seen high.
REQ-018 mem_rdata_i  in  32  Memory read data, combinational from mem_addr_o.

Function
REQ-019 FSM states SHALL be IDLE, REQ, RESP, ERR.
REQ-020 IDLE: on psel_i=1 and penable_i=0 (setup phase, cycle T) the block SHALL latch paddr_i, pwrite_i, pwdata_i and decode the address.
REQ-021 Decode error SHALL be paddr_i[1:0]!=0 or paddr_i[ADDR_W-1:6]!=0; otherwise mem_addr_o SHALL be paddr_i[5:2] and mem_rnw_o SHALL be !pwrite_i.
REQ-022 Decode error: IDLE->ERR; ERR SHALL drive pready_o=1 and pslverr_o=1 for one cycle (T+1), never raise mem_req_o, then return to IDLE.
REQ-023 Valid decode: IDLE->REQ; mem_req_o=1 from cycle T+1, with mem_addr_o, mem_rnw_o and mem_wdata_o held stable for the whole of REQ.
REQ-024 REQ: on the first cycle with mem_ready_i=1 (nominally T+2) the block SHALL capture mem_rdata_i (reads) and move to RESP, dropping mem_req_o at T+3.
REQ-025 Write commit SHALL occur in the memory at the edge ending the cycle where mem_req_o and mem_ready_i are both 1.
REQ-026 RESP: pready_o=1 for exactly one cycle (nominally T+3), pslverr_o=0, prdata_o=captured data on reads and 0 on writes; then return to IDLE.
REQ-027 Nominal latency SHALL be two APB wait states for a valid access and zero for a decode error.
REQ-028 Timeout: a counter SHALL clear on REQ entry and increment each REQ cycle with mem_ready_i=0; after TIMEOUT such cycles the FSM SHALL go to RESP with pslverr_o=1, prdata_o=0, and mem_req_o dropped.
REQ-029 mem_req_o SHALL be low for at least one cycle between any two requests, so mem_ready_i is low on every REQ entry.
REQ-030 Abort: if psel_i falls while in REQ, the FSM SHALL return to IDLE next cycle with mem_req_o=0 and no pready_o pulse.
REQ-031 pready_o and pslverr_o SHALL be 0 in IDLE and REQ; prdata_o SHALL hold its value outside RESP.
REQ-032 A setup phase arriving in any state other than IDLE SHALL be ignored.

Reset
REQ-033 On reset: FSM=IDLE, counter=0, and pready_o, pslverr_o, mem_req_o, mem_rnw_o set to 0; prdata_o, mem_addr_o, mem_wdata_o set to 0.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer without a memory write, provided reset is asserted before the commit edge.

Verification
REQ-035 Write 0xDEADBEEF to paddr 0x08, then read 0x08 -> mem_req_o high T+1..T+2, pready_o at T+3, read prdata_o=0xDEADBEEF, pslverr_o=0.
REQ-036 Read paddr 0x05 (misaligned) and paddr 0x40 (out of range) -> pready_o=1 and pslverr_o=1 at T+1, mem_req_o never high.
REQ-037 Hold mem_ready_i=0 and issue a read of 0x0C -> mem_req_o high T+1..T+8, pready_o=1 and pslverr_o=1 at T+9 (TIMEOUT=8), prdata_o=0.
REQ-038 Back-to-back writes to 0x00 and 0x3C with the minimum APB gap -> both commit, mem_req_o low at least one cycle between them, each completes with two wait states.
REQ-039 Assert reset at T+1 of a write to 0x10 -> all outputs 0 immediately, FSM in IDLE, location 0x10 unchanged on readback.
REQ-040 Drop psel_i at T+2 of a read -> mem_req_o=0 at T+3, no pready_o pulse, next transfer completes normally.

Source files
------------

// File: rtl/apb_mem_bridge.sv
// APB-to-memory bridge: decodes a single APB access into a word request on a
// 16-entry memory port. Bad addresses get an immediate error response. A
// memory that never acknowledges ends the access with an error after TIMEOUT
// cycles. Dropping psel while waiting abandons the access without a response.
module apb_mem_bridge #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic              pready_o,
    output logic [31:0]       prdata_o,
    output logic              pslverr_o,
    output logic              mem_req_o,
    output logic              mem_rnw_o,
    output logic [3:0]        mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic [31:0]        prdata_q, prdata_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_rnw_q, mem_rnw_d;
    logic [3:0]         mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    // Only word-aligned addresses inside the 64-byte window reach the memory.
    function automatic logic decode_err(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00) || (addr[ADDR_W-1:6] != {(ADDR_W-6){1'b0}});
    endfunction

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = prdata_q;
        mem_req_d   = mem_req_q;
        mem_rnw_d   = mem_rnw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (psel_i && !penable_i) begin
                    if (decode_err(paddr_i)) begin
                        state_d   = ERR;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_rnw_d   = !pwrite_i;
                        mem_addr_d  = paddr_i[5:2];
                        mem_wdata_d = pwdata_i;
                        cnt_d       = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (!psel_i) begin
                    // Master gave up: withdraw the request, no response.
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (mem_ready_i) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    pready_d  = 1'b1;
                    prdata_d  = mem_rnw_q ? mem_rdata_i : 32'h0000_0000;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State, timeout counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= 32'h0000_0000;
            mem_req_q   <= 1'b0;
            mem_rnw_q   <= 1'b0;
            mem_addr_q  <= 4'h0;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            prdata_q    <= prdata_d;
            mem_req_q   <= mem_req_d;
            mem_rnw_q   <= mem_rnw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign pready_o    = pready_q;
    assign pslverr_o   = pslverr_q;
    assign prdata_o    = prdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_rnw_o   = mem_rnw_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Bench for apb_mem_bridge: APB master tasks, a 16-word memory with one-cycle
// acknowledge, and a scoreboard queue of expected responses.
module tb_apb_mem_bridge;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [31:0]   pwdata = 32'h0;
    logic          pready, pslverr, mem_req, mem_rnw, mem_ready;
    logic [31:0]   prdata, mem_wdata, mem_rdata;
    logic [3:0]    mem_addr;

    apb_mem_bridge #(.ADDR_W(AW), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata),
        .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
        .mem_req_o(mem_req), .mem_rnw_o(mem_rnw), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int req_total = 0;
    logic stall = 1'b0;

    typedef struct {
        int          t0;
        int          lat;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    logic        init_done = 1'b0;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 | (i * 32'h0000_0101);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Cycle counter used to measure response latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory acknowledge: one cycle after a request is seen, unless stalled.
    always @(posedge clk or posedge reset) begin
        if (reset) mem_ready <= 1'b0;
        else       mem_ready <= mem_req & ~mem_ready & ~stall;
    end

    // Memory array: preload once, then commit writes on request+ready.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 16; i++) slv_mem[i] <= init_word(i);
            init_done <= 1'b1;
        end else if (mem_req && mem_ready && !mem_rnw) begin
            slv_mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = slv_mem[mem_addr];

    // Scoreboard: every pready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req) req_total++;
            if (pready) begin
                if (sb_q.size() == 0) begin
                    check_val("unexp_pready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_val("latency", 32'(cyc - e.t0), 32'(e.lat));
                    check_val("pslverr", {31'd0, pslverr}, {31'd0, e.err});
                    if (e.chk_data) check_val("prdata", prdata, e.data);
                end
            end
        end
    end

    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd);
        exp_t e;
        int   req0;
        logic bad;
        int   exp_reqs;
        bit   seen;
        bad = (addr[1:0] != 2'b00) || (addr[AW-1:6] != '0);
        e.chk_data = 1'b0;
        e.data = 32'h0;
        if (bad) begin
            e.lat = 1; e.err = 1'b1; exp_reqs = 0;
        end else if (stall) begin
            e.lat = 9; e.err = 1'b1; exp_reqs = 8; e.chk_data = 1'b1;
        end else begin
            e.lat = 3; e.err = 1'b0; exp_reqs = 2; e.chk_data = 1'b1;
            e.data = wr ? 32'h0 : ref_mem[addr[5:2]];
            if (wr) ref_mem[addr[5:2]] = wd;
        end
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        e.t0 = cyc;
        req0 = req_total;
        sb_q.push_back(e);
        @(posedge clk); #1;
        penable = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pready) seen = 1;
        end
        if (!seen) check_val("pready_timeout", 32'd0, 32'd1);
        check_val("req_cycles", 32'(req_total - req0), 32'(exp_reqs));
    endtask

    task automatic idle_bus(input int n);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_pready",  {31'd0, pready},  32'd0);
        check_val("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_mem_rnw", {31'd0, mem_rnw}, 32'd0);
        check_val("rst_prdata",  prdata, 32'd0);
        check_val("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Write then read back one word.
        apb_xfer(1'b1, 12'h008, 32'hDEAD_BEEF);
        idle_bus(2);
        apb_xfer(1'b0, 12'h008, 32'h0);
        idle_bus(1);
        apb_xfer(1'b0, 12'h024, 32'h0);
        idle_bus(1);

        // Decode errors: misaligned and out of window.
        apb_xfer(1'b0, 12'h005, 32'h0);
        idle_bus(1);
        apb_xfer(1'b0, 12'h040, 32'h0);
        idle_bus(1);
        apb_xfer(1'b1, 12'h802, 32'h1234_5678);
        idle_bus(1);

        // Memory never acknowledges: timeout error.
        stall = 1'b1;
        apb_xfer(1'b0, 12'h00C, 32'h0);
        idle_bus(1);
        stall = 1'b0;

        // Back-to-back writes with minimum gap, then read both back.
        apb_xfer(1'b1, 12'h000, 32'h0BAD_F00D);
        apb_xfer(1'b1, 12'h03C, 32'hCAFE_0001);
        apb_xfer(1'b0, 12'h000, 32'h0);
        apb_xfer(1'b0, 12'h03C, 32'h0);
        idle_bus(2);

        // Reset in the first access cycle of a write to 0x10.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        penable = 1'b1;
        reset = 1'b1;
        #1;
        check_val("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("mid_rst_pready",  {31'd0, pready},  32'd0);
        check_val("mid_rst_pslverr", {31'd0, pslverr}, 32'd0);
        check_val("mid_rst_mem_rnw", {31'd0, mem_rnw}, 32'd0);
        check_val("mid_rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        check_val("mid_rst_mem_wdata", mem_wdata, 32'd0);
        check_val("mid_rst_prdata", prdata, 32'd0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        apb_xfer(1'b0, 12'h010, 32'h0);
        idle_bus(1);

        // Master drops psel in the second access cycle of a read.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h014;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("abort_mem_req", {31'd0, mem_req}, 32'd0);
        repeat (4) @(posedge clk);
        apb_xfer(1'b0, 12'h014, 32'h0);
        idle_bus(3);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
